// File: rtl/instr_mem_loader_pkg.sv
// loader_pkg: shared loader state encoding and frame layout constants
package loader_pkg;
  typedef enum logic [3:0] {IDLE, CNT_LO, CNT_HI, B0, B1, B2, WRITE, CHK, DONE, ERR} state_e;
  localparam int BYTES_PER_WORD = 3;
  localparam int CNT_BYTES = 2;
endpackage

// File: rtl/instr_mem_loader_if.sv
// loader_if: byte stream in, instruction-memory write port and status out
//   master: stream source / controller (drives start, in_valid, in_data)
//   slave : the loader (drives in_ready, im_*, cpu_hold, done, err)
interface loader_if #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 19
);
  logic               start;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               im_we;
  logic [ADDR_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_wdata;
  logic               cpu_hold;
  logic               done;
  logic               err;
  modport master (
    output start, in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err
  );
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/instr_mem_loader_xor_checksum_8.sv
// xor_checksum_8: registered running XOR of accepted bytes
//   clear_i has priority over en_i; sum_o is the XOR of all bytes since the last clear.
module xor_checksum_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o
);
  logic [7:0] sum_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sum_q <= '0;
    else if (clear_i) sum_q <= '0;
    else if (en_i) sum_q <= sum_q ^ byte_i;
  assign sum_o = sum_q;
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a framed byte stream into instruction memory and gates CPU reset
//   clk, rst (async, active-low); bus: loader_if.slave carrying the stream handshake,
//   the instruction-memory write port and cpu_hold/done/err status.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int INSTR_W   = 19,
  parameter int MAX_WORDS = 4096
) (
  input logic     clk,
  input logic     rst,
  loader_if.slave bus
);
  // Word count and index are one bit wider than the address so MAX_WORDS itself is expressible.
  localparam int CW = ADDR_W + 1;
  state_e             state_q, state_d;
  logic [7:0]         cnt_lo_q, b0_q, b1_q, sum;
  logic [CW-1:0]      cnt_q, idx_q, n_in;
  logic [ADDR_W-1:0]  addr_q;
  logic [INSTR_W-1:0] wdata_q, word;
  logic               rdy_q, acc, go, bad_hi;
  assign acc    = bus.in_valid && rdy_q;
  assign go     = bus.start && (state_q inside {IDLE, DONE, ERR});
  assign n_in   = {bus.in_data[CW-9:0], cnt_lo_q};
  assign word   = {bus.in_data[INSTR_W-17:0], b1_q, b0_q};
  // Bits of B2 above the instruction word must be zero.
  assign bad_hi = (bus.in_data >> (INSTR_W - 16)) != 8'd0;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: state_d = go ? CNT_LO : state_q;
      CNT_LO: state_d = acc ? CNT_HI : state_q;
      CNT_HI: state_d = !acc ? state_q : n_in > CW'(MAX_WORDS) ? ERR : n_in == '0 ? CHK : B0;
      B0:     state_d = acc ? B1 : state_q;
      B1:     state_d = acc ? B2 : state_q;
      B2:     state_d = !acc ? state_q : bad_hi ? ERR : WRITE;
      WRITE:  state_d = idx_q + CW'(1) == cnt_q ? CHK : B0;
      CHK:    state_d = !acc ? state_q : bus.in_data == sum ? DONE : ERR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      cnt_lo_q <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= state_d inside {CNT_LO, CNT_HI, B0, B1, B2, CHK};
      if (acc && state_q == CNT_LO) cnt_lo_q <= bus.in_data;
      if (acc && state_q == CNT_HI) cnt_q <= n_in;
      if (acc && state_q == B0) b0_q <= bus.in_data;
      if (acc && state_q == B1) b1_q <= bus.in_data;
      // Address and data are captured on entry to WRITE and then held until the next word.
      if (state_d == WRITE) begin
        addr_q  <= idx_q[ADDR_W-1:0];
        wdata_q <= word;
      end
      idx_q <= go ? '0 : state_q == WRITE ? idx_q + CW'(1) : idx_q;
    end
  xor_checksum_8 u_chk (
    .clk     (clk),
    .rst     (rst),
    .clear_i (go),
    .en_i    (acc && state_q != CHK),
    .byte_i  (bus.in_data),
    .sum_o   (sum)
  );
  assign bus.in_ready = rdy_q;
  assign bus.im_we    = state_q == WRITE;
  assign bus.im_addr  = addr_q;
  assign bus.im_wdata = wdata_q;
  assign bus.done     = state_q == DONE;
  assign bus.err      = state_q == ERR;
  assign bus.cpu_hold = state_q != DONE;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed frame vectors plus backpressure, reset and max-count sequences
module tb_instr_mem_loader;
  typedef struct packed {
    logic [7:0]        len;
    logic [15:0][7:0]  b;
    logic              done;
    logic              err;
    logic [1:0]        nw;
    logic [18:0]       w0;
    logic [18:0]       w1;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [11:0] wa[$];
  logic [18:0] wd[$];
  vec_t v[7];
  logic [7:0]  bp[12];
  logic [18:0] bp_w[3];
  loader_if #(.ADDR_W(12), .INSTR_W(19)) bus();
  instr_mem_loader #(.ADDR_W(12), .INSTR_W(19), .MAX_WORDS(4096)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.im_we) begin
    wa.push_back(bus.im_addr);
    wd.push_back(bus.im_wdata);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int n = 0;
    if (rnd) repeat ($urandom_range(0, 2)) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n == 200) begin
      errors++;
      $display("FAIL accept_timeout byte=%0h got=no_ready expected=ready", b);
    end
    @(negedge clk);
    if (rnd) bus.in_valid = $urandom_range(0, 1) == 1;
  endtask
  task automatic run(input vec_t t, input string tag);
    wa.delete();
    wd.delete();
    pulse_start();
    for (int k = 0; k < int'(t.len); k++) send_byte(t.b[k], 1'b0);
    bus.in_valid = 1'b0;
    chk({tag, "_done"}, bus.done, t.done);
    chk({tag, "_err"}, bus.err, t.err);
    chk({tag, "_hold"}, bus.cpu_hold, !t.done);
    chk({tag, "_ready"}, bus.in_ready, 0);
    chk({tag, "_nwrites"}, wa.size(), t.nw);
    if (t.nw > 0 && wa.size() > 0) begin
      chk({tag, "_addr0"}, wa[0], 0);
      chk({tag, "_data0"}, wd[0], t.w0);
    end
    if (t.nw > 1 && wa.size() > 1) begin
      chk({tag, "_addr1"}, wa[1], 1);
      chk({tag, "_data1"}, wd[1], t.w1);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    // Frame bytes are listed little-endian: byte 0 is the rightmost.
    v[0] = '{len: 6, b: 128'h66_05_A3_C1_00_01, done: 1, err: 0, nw: 1, w0: 19'h5A3C1, w1: 0};
    v[1] = '{len: 6, b: 128'h67_05_A3_C1_00_01, done: 0, err: 1, nw: 1, w0: 19'h5A3C1, w1: 0};
    v[2] = '{len: 3, b: 128'h00_00_00, done: 1, err: 0, nw: 0, w0: 0, w1: 0};
    v[3] = '{len: 5, b: 128'h08_00_00_00_01, done: 0, err: 1, nw: 0, w0: 0, w1: 0};
    v[4] = '{len: 6, b: 128'h86_05_A3_C1_E0_01, done: 1, err: 0, nw: 1, w0: 19'h5A3C1, w1: 0};
    v[5] = '{len: 2, b: 128'h10_01, done: 0, err: 1, nw: 0, w0: 0, w1: 0};
    v[6] = '{len: 9, b: 128'h25_06_55_44_03_22_11_00_02, done: 1, err: 0, nw: 2, w0: 19'h32211, w1: 19'h65544};
    bp   = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'h07, 8'hFF, 8'hFF, 8'h04, 8'h11};
    bp_w = '{19'h30201, 19'h7BBAA, 19'h4FFFF};
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_hold", bus.cpu_hold, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_we", bus.im_we, 0);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_addr", bus.im_addr, 0);
    chk("rst_wdata", bus.im_wdata, 0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) run(v[i], $sformatf("v%0d", i));
    wa.delete();
    wd.delete();
    pulse_start();
    for (int k = 0; k < 12; k++) send_byte(bp[k], 1'b1);
    bus.in_valid = 1'b0;
    chk("bp_done", bus.done, 1);
    chk("bp_nwrites", wa.size(), 3);
    for (int k = 0; k < 3; k++) if (wa.size() > k) begin
      chk($sformatf("bp_addr%0d", k), wa[k], k);
      chk($sformatf("bp_data%0d", k), wd[k], bp_w[k]);
    end
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hC1, 1'b0);
    bus.in_valid = 1'b0;
    chk("pre_rst_hold", bus.cpu_hold, 1);
    chk("pre_rst_ready", bus.in_ready, 1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_hold", bus.cpu_hold, 1);
    chk("mid_rst_ready", bus.in_ready, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_addr", bus.im_addr, 0);
    chk("mid_rst_wdata", bus.im_wdata, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(v[0], "after_rst");
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    for (int k = 0; k < 3 * 4096; k++) send_byte(8'h00, 1'b0);
    chk("max_hold_before_chk", bus.cpu_hold, 1);
    send_byte(8'h10, 1'b0);
    bus.in_valid = 1'b0;
    chk("max_done", bus.done, 1);
    chk("max_nwrites", wa.size(), 4096);
    if (wa.size() == 4096) chk("max_last_addr", wa[4095], 12'hFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
